// File: rtl/posit_defines.sv
// Shared posit format definitions: word geometry and the unpacked value record
// handed from the decoder to the posit arithmetic units.
package posit_defines;

    localparam int NBITS   = 32;
    localparam int ES      = 2;
    localparam int FBITS   = NBITS - 3 - ES;
    localparam int SCALE_W = 8;
    localparam int RUN_W   = $clog2(NBITS);

    // Not-a-Real pattern: sign bit set, every other bit clear
    localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};

    // Unpacked posit as seen by the multiplier and adder stages
    typedef struct packed {
        logic                      sign;
        logic signed [SCALE_W-1:0] scale;
        logic [ES-1:0]             exponent;
        logic [FBITS-1:0]          fraction;
        logic                      inf;
        logic                      zero;
    } value;

    // First pipeline slot: sign, magnitude bits below the sign, special flags
    typedef struct packed {
        logic             sign;
        logic [NBITS-2:0] mag;
        logic             zero;
        logic             inf;
    } s1_slot_t;

endpackage

// File: rtl/posit_lead_run.sv
// Regime run detector: reports the leading bit of the regime field and the
// number of consecutive copies of it, counted from the MSB.
module posit_lead_run
    import posit_defines::*;
(
    input  logic [NBITS-2:0] r_i,
    output logic             run_bit_o,
    output logic [RUN_W-1:0] run_len_o
);

    logic run_stop;

    // Walk from the MSB down, counting bits equal to the first one until a flip
    always_comb begin
        run_bit_o = r_i[NBITS-2];
        run_len_o = '0;
        run_stop  = 1'b0;
        for (int i = NBITS - 2; i >= 0; i--) begin
            if (!run_stop && (r_i[i] == r_i[NBITS-2])) begin
                run_len_o = run_len_o + RUN_W'(1);
            end else begin
                run_stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/posit_extract.sv
// Two-stage pipelined posit decoder with valid/ready handshaking on both sides.
// S1 captures sign, magnitude and the zero/NaR flags; S2 decodes the regime,
// exponent and fraction and its registers drive out_value directly.
module posit_extract
    import posit_defines::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output value             out_value,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic signed [SCALE_W-1:0] ONE_S = 1;

    // Magnitude of a posit word: two's-complement negate when the sign is set
    function automatic logic [NBITS-1:0] posit_abs(input logic [NBITS-1:0] x);
        return x[NBITS-1] ? (~x + NBITS'(1)) : x;
    endfunction

    // scale = k * 2^ES + exponent, with k = m-1 for a run of ones, -m for zeros
    function automatic logic signed [SCALE_W-1:0] calc_scale(
        input logic             run_bit,
        input logic [RUN_W-1:0] run_len,
        input logic [ES-1:0]    expo
    );
        logic signed [SCALE_W-1:0] m_s;
        logic signed [SCALE_W-1:0] k_s;
        m_s = $signed({{(SCALE_W-RUN_W){1'b0}}, run_len});
        k_s = run_bit ? (m_s - ONE_S) : -m_s;
        return (k_s <<< ES) + $signed({{(SCALE_W-ES){1'b0}}, expo});
    endfunction

    logic             s1_vld_q, s1_vld_d;
    s1_slot_t         s1_q, s1_d;
    logic             s2_vld_q, s2_vld_d;
    value             s2_q, s2_d;

    logic             s2_load;
    logic             s1_load;
    logic [NBITS-1:0] in_abs;

    logic             run_bit;
    logic [RUN_W-1:0] run_len;
    logic [RUN_W:0]   tail_shamt;
    logic [ES+FBITS-1:0] tail;
    value             dec;

    // S2 accepts whenever it is empty or its item leaves; S1 whenever it can shift
    assign s2_load  = !s2_vld_q || out_ready;
    assign s1_load  = !s1_vld_q || s2_load;
    assign in_ready = s1_load;
    assign in_abs   = posit_abs(in_data);

    // ---------------- Stage 1: sign, magnitude, special flags ----------------
    // Next S1 slot: capture the input word whenever S1 is free to shift
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_d     = s1_q;
        if (s1_load) begin
            s1_vld_d = in_valid;
            s1_d.sign = in_data[NBITS-1];
            s1_d.mag  = in_abs[NBITS-2:0];
            s1_d.zero = (in_data == '0);
            s1_d.inf  = (in_data == NAR);
        end
    end

    // S1 occupancy is the only S1 state that needs a reset value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
        end
    end

    // S1 payload; never observed unless s1_vld_q is set
    always_ff @(posedge clk) begin
        s1_q <= s1_d;
    end

    // ---------------- Stage 2: regime, exponent, fraction, scale ----------------
    posit_lead_run u_lead_run (
        .r_i       (s1_q.mag),
        .run_bit_o (run_bit),
        .run_len_o (run_len)
    );

    // Drop the regime run plus its terminator; a full-width run leaves nothing.
    // The low bits beyond exponent+fraction fall off the bottom.
    assign tail_shamt = {1'b0, run_len} + (RUN_W+1)'(1);
    assign tail       = (ES+FBITS)'((s1_q.mag << tail_shamt) >> (NBITS-1-ES-FBITS));

    // Decoded record for the S1 slot; all fields zero when the slot is empty
    always_comb begin
        dec = '0;
        if (s1_vld_q) begin
            if (s1_q.zero) begin
                dec.zero = 1'b1;
            end else if (s1_q.inf) begin
                dec.inf  = 1'b1;
                dec.sign = 1'b1;
            end else begin
                dec.sign     = s1_q.sign;
                dec.exponent = tail[ES+FBITS-1 -: ES];
                dec.fraction = tail[FBITS-1:0];
                dec.scale    = calc_scale(run_bit, run_len, tail[ES+FBITS-1 -: ES]);
            end
        end
    end

    // Next S2 contents: load from S1 when allowed, otherwise hold for the stall
    always_comb begin
        s2_vld_d = s2_vld_q;
        s2_d     = s2_q;
        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            s2_d     = dec;
        end
    end

    // S2 registers feed the output port, so both valid and record are cleared on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            s2_q     <= '0;
        end else begin
            s2_vld_q <= s2_vld_d;
            s2_q     <= s2_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign out_value = s2_q;

endmodule

// File: tb/tb_posit_extract.sv
// Self-checking bench for posit_extract: directed table, randomized
// backpressure stream against a bit-queue reference decoder, mid-stream reset.
`timescale 1ns/1ps
module tb_posit_extract;
    import posit_defines::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NBITS-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    value             out_value;
    logic             out_valid;
    logic             out_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    posit_extract dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_value (out_value),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NBITS-1:0] din;
        value             exp;
        string            name;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    function automatic value mk(input logic s, input int sc, input int e,
                                input logic [FBITS-1:0] f, input logic inf, input logic z);
        value v;
        v.sign     = s;
        v.scale    = SCALE_W'(sc);
        v.exponent = ES'(e);
        v.fraction = f;
        v.inf      = inf;
        v.zero     = z;
        return v;
    endfunction

    // Reference decoder: read the magnitude as a stream of bits and consume
    // regime run, terminator, exponent and fraction fields in order.
    function automatic value ref_decode(input logic [NBITS-1:0] p);
        value             v;
        bit               q[$];
        logic [NBITS-1:0] a;
        bit               rb;
        int               m, k, e;
        v = '0;
        if (p == '0) begin
            v.zero = 1'b1;
            return v;
        end
        if (p == NAR) begin
            v.inf  = 1'b1;
            v.sign = 1'b1;
            return v;
        end
        v.sign = p[NBITS-1];
        a = v.sign ? (~p + 1) : p;
        for (int i = NBITS - 2; i >= 0; i--) q.push_back(a[i]);
        rb = q[0];
        m = 0;
        while (q.size() > 0 && q[0] == rb) begin
            void'(q.pop_front());
            m++;
        end
        if (q.size() > 0) void'(q.pop_front());
        e = 0;
        for (int i = 0; i < ES; i++) begin
            e = e * 2;
            if (q.size() > 0) e = e + int'(q.pop_front());
        end
        k = rb ? (m - 1) : -m;
        v.exponent = ES'(e);
        v.scale    = SCALE_W'(k * (1 << ES) + e);
        for (int i = FBITS - 1; i >= 0; i--) begin
            if (q.size() > 0) v.fraction[i] = q.pop_front();
            else v.fraction[i] = 1'b0;
        end
        return v;
    endfunction

    function automatic logic [NBITS-1:0] rand_posit();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return NAR;
            2: return 32'h4000_0000;
            3: return 32'h0000_0001 << $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input value act, input value exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got s=%b sc=%0d e=%0d f=%h inf=%b z=%b expected s=%b sc=%0d e=%0d f=%h inf=%b z=%b",
                     name, act.sign, act.scale, act.exponent, act.fraction, act.inf, act.zero,
                     exp.sign, exp.scale, exp.exponent, exp.fraction, exp.inf, exp.zero);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [NBITS-1:0] d, input value x, input string n);
        vecs[i].din  = d;
        vecs[i].exp  = x;
        vecs[i].name = n;
    endtask

    value  expq[$];
    value  prev_val;
    value  want;
    logic  stalled;
    logic  in_fire, out_fire;
    int    sent;

    localparam int TOTAL  = 80;
    localparam int CYCLES = 500;
    localparam int DRAIN  = 420;

    initial begin
        set_vec(0, 32'h4000_0000, mk(0,    0, 0, '0,           0, 0), "one");
        set_vec(1, 32'h4800_0000, mk(0,    1, 1, '0,           0, 0), "two");
        set_vec(2, 32'hC000_0000, mk(1,    0, 0, '0,           0, 0), "neg_one");
        set_vec(3, 32'h0000_0001, mk(0, -120, 0, '0,           0, 0), "minpos");
        set_vec(4, 32'h7FFF_FFFF, mk(0,  120, 0, '0,           0, 0), "maxpos");
        set_vec(5, 32'h0000_0000, mk(0,    0, 0, '0,           0, 1), "zero");
        set_vec(6, 32'h8000_0000, mk(1,    0, 0, '0,           1, 0), "nar");
        set_vec(7, 32'h4C00_0000, mk(0,    1, 1, 27'h4000000,  0, 0), "frac");
        set_vec(8, 32'h0800_0000, mk(0,  -12, 0, '0,           0, 0), "negreg");
        set_vec(9, 32'hB800_0000, mk(1,    1, 1, '0,           0, 0), "neg_two");

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_val("rst_out_value", out_value, '0);
        check_bit("rst_in_ready", in_ready, 1'b1);

        // Directed vectors, one at a time, exact 2-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            in_data  = vecs[i].din;
            in_valid = 1'b1;
            check_bit({vecs[i].name, "_rdy"}, in_ready, 1'b1);
            tick();
            in_valid = 1'b0;
            check_bit({vecs[i].name, "_lat1"}, out_valid, 1'b0);
            tick();
            check_bit({vecs[i].name, "_vld"}, out_valid, 1'b1);
            check_val(vecs[i].name, out_value, vecs[i].exp);
            tick();
            check_bit({vecs[i].name, "_gone"}, out_valid, 1'b0);
        end

        // Randomized stream with backpressure; first 16 items back-to-back
        sent     = 0;
        stalled  = 1'b0;
        prev_val = '0;
        in_valid = 1'b1;
        in_data  = rand_posit();
        out_ready = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            check_bit("in_ready_rule", in_ready, !(expq.size() == 2 && !out_ready));
            if (stalled) begin
                check_bit("stall_valid", out_valid, 1'b1);
                check_val("stall_hold", out_value, prev_val);
            end
            if (out_fire) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra: got output with %0d expected items", expq.size());
                end else begin
                    want = expq.pop_front();
                    check_val("stream", out_value, want);
                end
            end
            if (in_fire) expq.push_back(ref_decode(in_data));
            stalled  = out_valid && !out_ready;
            prev_val = out_value;
            @(posedge clk);
            #1;
            if (in_fire) sent++;
            if (in_fire || !in_valid) begin
                if (sent < TOTAL && (sent < 16 || $urandom_range(0, 3) != 0)) begin
                    in_valid = 1'b1;
                    in_data  = rand_posit();
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = (cyc >= DRAIN) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        checks++;
        if (expq.size() != 0 || sent != TOTAL) begin
            errors++;
            $display("FAIL stream_drain: got %0d left, %0d sent, required 0 left, %0d sent",
                     expq.size(), sent, TOTAL);
        end

        // Reset with two items in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h4000_0000;
        tick();
        in_data   = 32'h4800_0000;
        tick();
        in_valid  = 1'b0;
        check_bit("pre_rst_valid", out_valid, 1'b1);
        check_bit("pre_rst_full", in_ready, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_bit("mid_rst_out_valid", out_valid, 1'b0);
        check_val("mid_rst_out_value", out_value, '0);
        check_bit("mid_rst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        in_data   = 32'h4000_0000;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        check_bit("post_rst_lat1", out_valid, 1'b0);
        tick();
        check_bit("post_rst_vld", out_valid, 1'b1);
        check_val("post_rst_val", out_value, mk(0, 0, 0, '0, 0, 0));
        tick();
        check_bit("post_rst_no_ghost", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
